// File: rtl/beam_scan.sv
// Delay-and-sum beam scanner: coherently combines NMIC channel spectra at one FFT bin
// against NBEAM steering vectors and reports the strongest beam, its power and DOA.
module beam_scan #(
  parameter int NMIC  = 4,
  parameter int NBEAM = 13,
  parameter int DW    = 14,
  parameter int BINW  = 10,
  parameter int BW    = 4,
  parameter int ANG0  = -90,
  parameter int ASTEP = 15,
  localparam int AW   = 2*DW + 1 + $clog2(NMIC),
  localparam int PW   = 2*AW,
  localparam int CAW  = $clog2(NMIC*NBEAM)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [BINW-1:0]        bin,
  output logic [BINW-1:0]        bin_addr,
  input  logic [NMIC*2*DW-1:0]   spec,
  output logic [CAW-1:0]         coef_addr,
  input  logic [2*DW-1:0]        coef,
  input  logic [PW-1:0]          threshold,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic [BW-1:0]          best_beam,
  output logic [7:0]             doa,
  output logic [PW-1:0]          best_pwr,
  output logic                   pwr_valid,
  output logic [BW-1:0]          pwr_beam,
  output logic [PW-1:0]          pwr_data
);

  localparam int MW  = $clog2(NMIC + 1);
  localparam int MIW = $clog2(NMIC);
  localparam int PRW = 2*DW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD0, S_LOAD1, S_MAC, S_POWER, S_CMP, S_FIN
  } state_e;

  state_e state_q, state_d;

  logic [BINW-1:0]       bin_addr_q;
  logic [BW-1:0]         beam_q;
  logic [MW-1:0]         mic_q;
  logic signed [AW-1:0]  acc_re_q, acc_im_q;
  logic [PW-1:0]         pwr_q;
  logic [PW-1:0]         max_pwr_q;
  logic [BW-1:0]         max_beam_q;
  logic [BW-1:0]         best_beam_q;
  logic [PW-1:0]         best_pwr_q;
  logic [7:0]            doa_q;
  logic                  valid_q;

  logic signed [DW-1:0]  spec_re_w [NMIC];
  logic signed [DW-1:0]  spec_im_w [NMIC];
  logic signed [DW-1:0]  spec_re_q [NMIC];
  logic signed [DW-1:0]  spec_im_q [NMIC];

  for (genvar gi = 0; gi < NMIC; gi++) begin : g_chan
    assign spec_re_w[gi] = spec[gi*2*DW + DW +: DW];
    assign spec_im_w[gi] = spec[gi*2*DW +: DW];
  end

  logic mac_done, last_beam;
  assign mac_done  = (mic_q == MW'(NMIC));
  assign last_beam = (beam_q == BW'(NBEAM - 1));

  // Coefficient for mic k arrives in MAC cycle k+1, so pair it with spectrum entry k.
  logic [MIW-1:0]        k_idx;
  logic signed [DW-1:0]  ar, ai, br, bi;
  logic signed [PRW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PRW-1:0] prod_re, prod_im;

  assign k_idx   = MIW'(mic_q - MW'(1));
  assign ar      = coef[2*DW-1:DW];
  assign ai      = coef[DW-1:0];
  assign br      = spec_re_q[k_idx];
  assign bi      = spec_im_q[k_idx];
  assign ar_x    = PRW'(ar);
  assign ai_x    = PRW'(ai);
  assign br_x    = PRW'(br);
  assign bi_x    = PRW'(bi);
  assign prod_re = ar_x*br_x - ai_x*bi_x;
  assign prod_im = ar_x*bi_x + ai_x*br_x;

  logic signed [PW-1:0] re_x, im_x, sq_sum;
  assign re_x   = PW'(acc_re_q);
  assign im_x   = PW'(acc_im_q);
  assign sq_sum = re_x*re_x + im_x*im_x;

  // Beam 0 seeds the running max; strict compare keeps the lowest index on ties.
  logic          better;
  logic [PW-1:0] new_max_pwr;
  logic [BW-1:0] new_max_beam;
  assign better       = (beam_q == '0) || (pwr_q > max_pwr_q);
  assign new_max_pwr  = better ? pwr_q  : max_pwr_q;
  assign new_max_beam = better ? beam_q : max_beam_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD0;
      S_LOAD0: state_d = S_LOAD1;
      S_LOAD1: state_d = S_MAC;
      S_MAC:   if (mac_done) state_d = S_POWER;
      S_POWER: state_d = S_CMP;
      S_CMP:   state_d = last_beam ? S_FIN : S_MAC;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    pwr_valid = 1'b0;
    pwr_beam  = '0;
    pwr_data  = '0;
    coef_addr = '0;
    case (state_q)
      S_LOAD0, S_LOAD1, S_POWER: busy = 1'b1;
      S_MAC: begin
        busy = 1'b1;
        if (!mac_done) coef_addr = CAW'(int'(beam_q)*NMIC + int'(mic_q));
      end
      S_CMP: begin
        busy      = 1'b1;
        pwr_valid = 1'b1;
        pwr_beam  = beam_q;
        pwr_data  = pwr_q;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_addr_q  <= '0;
      beam_q      <= '0;
      mic_q       <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      pwr_q       <= '0;
      max_pwr_q   <= '0;
      max_beam_q  <= '0;
      best_beam_q <= '0;
      best_pwr_q  <= '0;
      doa_q       <= '0;
      valid_q     <= 1'b0;
      for (int i = 0; i < NMIC; i++) begin
        spec_re_q[i] <= '0;
        spec_im_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            bin_addr_q <= bin;
            beam_q     <= '0;
            mic_q      <= '0;
          end
        end
        S_LOAD1: begin
          for (int i = 0; i < NMIC; i++) begin
            spec_re_q[i] <= spec_re_w[i];
            spec_im_q[i] <= spec_im_w[i];
          end
        end
        S_MAC: begin
          if (mic_q == '0) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
          end else begin
            acc_re_q <= acc_re_q + AW'(prod_re);
            acc_im_q <= acc_im_q + AW'(prod_im);
          end
          mic_q <= mac_done ? '0 : mic_q + MW'(1);
        end
        S_POWER: pwr_q <= $unsigned(sq_sum);
        S_CMP: begin
          max_pwr_q  <= new_max_pwr;
          max_beam_q <= new_max_beam;
          if (!last_beam) begin
            beam_q <= beam_q + BW'(1);
          end else if (!abort) begin
            // Results become visible together with the done pulse in FIN.
            best_beam_q <= new_max_beam;
            best_pwr_q  <= new_max_pwr;
            doa_q       <= 8'(ANG0 + ASTEP*int'(new_max_beam));
            valid_q     <= (new_max_pwr >= threshold);
          end
        end
        default: ;
      endcase
    end
  end

  assign bin_addr  = bin_addr_q;
  assign best_beam = best_beam_q;
  assign best_pwr  = best_pwr_q;
  assign doa       = doa_q;
  assign valid     = valid_q;

endmodule
